cpu_run_ctrl: RTL

Run-control and watchdog block that sequences a CPU core from reset through execution to halt or timeout. It replaces the fixed reset-delay and fixed-duration run in the CPU bench with a synthesizable, parametrised controller. It holds the core in reset for a programmable period, counts executed cycles, and detects `halted` or a cycle-limit timeout. It also keeps a ring-buffer trace of recent PC values for post-mortem inspection. It sits between the top level (or bench) and `cpu`, driving the core's `rst` and observing `halted` and `pc_out`.

---
 rtl/cpu_run_pkg.sv | 24 ++
 rtl/pc_trace_buf.sv | 46 ++++
 rtl/cpu_run_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the CPU run-control block.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } run_state_t;

    localparam int unsigned DEF_PC_W        = 8;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_RST_CYCLES  = 2;
    localparam int unsigned DEF_TRACE_DEPTH = 16;

    // Trace index width for a given ring depth.
    function automatic int unsigned trace_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef logic [trace_idx_w(DEF_TRACE_DEPTH)-1:0] trace_idx_t;

endpackage

// File: rtl/pc_trace_buf.sv
// Ring buffer of recent PC values with write pointer and saturating fill count.
module pc_trace_buf #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TI_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we,
    input  logic [PC_W-1:0] din,
    input  logic [TI_W-1:0] idx,
    output logic [PC_W-1:0] dout,
    output logic [TI_W:0]   fill
);

    logic [PC_W-1:0] mem [DEPTH];
    logic [TI_W-1:0] wr_ptr;
    logic [TI_W-1:0] rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (we) begin
            wr_ptr <= wr_ptr + TI_W'(1);
            if (fill != (TI_W+1)'(DEPTH)) begin
                fill <= fill + (TI_W+1)'(1);
            end
        end
    end

    // Contents are not reset; entries beyond fill are stale by definition.
    always_ff @(posedge clk) begin
        if (we && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    assign rd_addr = wr_ptr - TI_W'(1) - idx;
    assign dout    = mem[rd_addr];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control and watchdog: sequences core reset, run, halt/timeout and traces PC.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter  int unsigned PC_W        = DEF_PC_W,
    parameter  int unsigned CNT_W       = DEF_CNT_W,
    parameter  int unsigned RST_CYCLES  = DEF_RST_CYCLES,
    parameter  int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH,
    localparam int unsigned TI_W        = $clog2(TRACE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycle_limit,
    input  logic             cpu_halted,
    input  logic [PC_W-1:0]  cpu_pc,
    output logic             cpu_rst,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    input  logic [TI_W-1:0]  trace_idx,
    output logic [PC_W-1:0]  trace_pc,
    output logic [TI_W:0]    trace_fill
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t       state, state_n;
    logic [RC_W-1:0]  rst_cnt, rst_cnt_n;
    logic [CNT_W-1:0] limit, limit_n;
    logic [CNT_W-1:0] cycle_count_n, cnt_inc;
    logic             cpu_rst_n, running_n, done_n, timeout_n;
    logic             trace_we, trace_clr, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            limit       <= '0;
            cycle_count <= '0;
            cpu_rst     <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            limit       <= limit_n;
            cycle_count <= cycle_count_n;
            cpu_rst     <= cpu_rst_n;
            running     <= running_n;
            done        <= done_n;
            timeout     <= timeout_n;
        end
    end

    assign cnt_inc = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
    assign accept  = start && (state == ST_IDLE || state == ST_HALTED || state == ST_TIMEOUT);

    always_comb begin
        state_n       = state;
        rst_cnt_n     = rst_cnt;
        limit_n       = limit;
        cycle_count_n = cycle_count;
        cpu_rst_n     = cpu_rst;
        running_n     = running;
        done_n        = done;
        timeout_n     = timeout;
        trace_we      = 1'b0;
        trace_clr     = 1'b0;

        case (state)
            ST_RESET: begin
                if (rst_cnt == '0) begin
                    state_n   = ST_RUN;
                    cpu_rst_n = 1'b0;
                    running_n = 1'b1;
                end else begin
                    rst_cnt_n = rst_cnt - RC_W'(1);
                end
            end
            ST_RUN: begin
                // Halt takes priority over tracing, counting and the limit check.
                if (cpu_halted) begin
                    state_n   = ST_HALTED;
                    done_n    = 1'b1;
                    running_n = 1'b0;
                end else begin
                    trace_we      = 1'b1;
                    cycle_count_n = cnt_inc;
                    if (limit != '0 && cnt_inc == limit) begin
                        state_n   = ST_TIMEOUT;
                        timeout_n = 1'b1;
                        cpu_rst_n = 1'b1;
                        running_n = 1'b0;
                    end
                end
            end
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A start from any resting state launches a fresh run.
        if (accept) begin
            state_n       = ST_RESET;
            rst_cnt_n     = RC_W'(RST_CYCLES - 1);
            limit_n       = cycle_limit;
            cycle_count_n = '0;
            cpu_rst_n     = 1'b1;
            running_n     = 1'b0;
            done_n        = 1'b0;
            timeout_n     = 1'b0;
            trace_clr     = 1'b1;
        end
    end

    pc_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH),
        .TI_W  (TI_W)
    ) u_trace (
        .clk  (clk),
        .rst  (rst),
        .clr  (trace_clr),
        .we   (trace_we),
        .din  (cpu_pc),
        .idx  (trace_idx),
        .dout (trace_pc),
        .fill (trace_fill)
    );

endmodule
